// File: rtl/user_mem_pkg.sv
// Shared types and helpers for the user-domain OBI scratch memory.
// Holds the default OBI channel structs, the response stage record and index sizing.
package user_mem_pkg;

  localparam int unsigned AddrWidth     = 32'd32;
  localparam int unsigned DataWidth     = 32'd32;
  localparam int unsigned IdWidth       = 32'd4;
  localparam int unsigned MaxRspLatency = 32'd4;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: 32'd32,
    DataWidth: 32'd32,
    IdWidth:   32'd4
  };

  typedef struct packed {
    logic [AddrWidth-1:0]        addr;
    logic                        we;
    logic [DataWidth/32'd8-1:0]  be;
    logic [DataWidth-1:0]        wdata;
    logic [IdWidth-1:0]          aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_default_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
    logic [0:0]           r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_default_t;

  typedef struct packed {
    logic                 valid;
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } rsp_stage_t;

  // A single-word memory still needs one index bit to keep the slice legal.
  function automatic int unsigned idx_width(input int unsigned num_words);
    int unsigned w;
    if (num_words > 32'd1) begin
      w = $clog2(num_words);
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/user_mem_rsp_pipe.sv
// Fixed-latency response delay line: every stage shifts each cycle, output is the last stage.
// Valid and payload both clear on reset so in-flight responses are dropped.
module user_mem_rsp_pipe
  import user_mem_pkg::*;
#(
  parameter int unsigned Depth = 32'd1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  rsp_stage_t stage_i,
  output rsp_stage_t stage_o
);

  rsp_stage_t stage_r [Depth];

  // Shift register of response stages
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= stage_i;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign stage_o = stage_r[Depth-1];

endmodule

// File: rtl/user_obi_mem.sv
// Single-port OBI scratch memory with byte-enabled writes, write protect,
// fixed response latency, range/protect error responses and a saturating error counter.
module user_obi_mem
  import user_mem_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg      = ObiDefaultConfig,
  parameter type         obi_req_t   = obi_req_default_t,
  parameter type         obi_rsp_t   = obi_rsp_default_t,
  parameter int unsigned NumWords    = 32'd16,
  parameter int unsigned RspLatency  = 32'd1,
  parameter int unsigned ErrCntWidth = 32'd8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  obi_req_t               obi_req_i,
  output obi_rsp_t               obi_rsp_o,
  input  logic                   wp_i,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  input  logic                   err_cnt_clr_i
);

  localparam int unsigned IdxW     = idx_width(NumWords);
  localparam int unsigned NumBytes = ObiCfg.DataWidth / 32'd8;

  logic [DataWidth-1:0]   mem_r [NumWords];
  logic [IdxW-1:0]        idx_s;
  logic                   range_err_s;
  logic                   bad_s;
  logic                   wr_en_s;
  logic                   unused_s;
  rsp_stage_t             stage_in_s;
  rsp_stage_t             stage_out_s;
  logic [ErrCntWidth-1:0] err_cnt_r;

  // Byte offset and upper address bits alias onto the word index.
  assign idx_s       = obi_req_i.a.addr[IdxW+1:2];
  assign unused_s    = ^obi_req_i.a.addr;
  assign range_err_s = (32'(idx_s) >= NumWords);
  assign bad_s       = range_err_s | (obi_req_i.a.we & wp_i);
  assign wr_en_s     = obi_req_i.req & obi_req_i.a.we & ~bad_s;

  // Build the response record for the request accepted this cycle
  always_comb begin
    stage_in_s = '0;
    if (obi_req_i.req) begin
      stage_in_s.valid = 1'b1;
      stage_in_s.id    = obi_req_i.a.aid;
      stage_in_s.err   = bad_s;
      if (!obi_req_i.a.we && !bad_s) begin
        stage_in_s.rdata = mem_r[idx_s];
      end else begin
        stage_in_s.rdata = '0;
      end
    end else begin
      stage_in_s = '0;
    end
  end

  // Memory array: cleared on reset, byte-lane writes on good accepted writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < int'(NumWords); w++) begin
        mem_r[w] <= '0;
      end
    end else if (wr_en_s) begin
      for (int k = 0; k < int'(NumBytes); k++) begin
        if (obi_req_i.a.be[k]) begin
          mem_r[idx_s][8*k +: 8] <= obi_req_i.a.wdata[8*k +: 8];
        end
      end
    end
  end

  user_mem_rsp_pipe #(
    .Depth (RspLatency)
  ) i_rsp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stage_i (stage_in_s),
    .stage_o (stage_out_s)
  );

  // Saturating error counter; clear wins over a same-cycle increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_r <= '0;
    end else if (err_cnt_clr_i) begin
      err_cnt_r <= '0;
    end else if (stage_out_s.valid && stage_out_s.err && (err_cnt_r != '1)) begin
      err_cnt_r <= err_cnt_r + ErrCntWidth'(1);
    end
  end

  // Drive the OBI response from the last pipeline stage; grant is immediate
  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = obi_req_i.req;
    obi_rsp_o.rvalid       = stage_out_s.valid;
    obi_rsp_o.r.rdata      = stage_out_s.rdata;
    obi_rsp_o.r.rid        = stage_out_s.id;
    obi_rsp_o.r.err        = stage_out_s.err;
    obi_rsp_o.r.r_optional = '0;
  end

  assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_user_obi_mem.sv
// Self-checking bench for user_obi_mem: directed vector table, multi-cycle corner
// sequences and random traffic against a queue-based reference model.
module tb_user_obi_mem;
  import user_mem_pkg::*;

  localparam int NW      = 12;
  localparam int LAT     = 3;
  localparam int ECW     = 2;
  localparam int IdxSpan = 1 << $clog2(NW);
  localparam int CntMax  = (1 << ECW) - 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             wp    = 1'b0;
  logic             clr   = 1'b0;
  obi_req_default_t obi_req = '0;
  obi_rsp_default_t obi_rsp;
  logic [ECW-1:0]   err_cnt;

  user_obi_mem #(
    .NumWords    (NW),
    .RspLatency  (LAT),
    .ErrCntWidth (ECW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .obi_req_i     (obi_req),
    .obi_rsp_o     (obi_rsp),
    .wp_i          (wp),
    .err_cnt_o     (err_cnt),
    .err_cnt_clr_i (clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [3:0]  id;
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic        wp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_rsp_t    pend[$];
  logic [31:0] mdl_mem [NW];
  int          mdl_cnt;
  int          cyc;
  int          errors = 0;
  int          checks = 0;
  logic        cur_valid, cur_err;
  logic [3:0]  cur_id;
  logic [31:0] cur_rdata;
  int          dut_rsp_seen;
  logic [31:0] dut_last_rdata;
  logic [3:0]  dut_last_id;
  logic        dut_last_err;
  vec_t        vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < NW; i++) mdl_mem[i] = 32'h0;
    mdl_cnt   = 0;
    cur_valid = 1'b0;
    cur_err   = 1'b0;
    cur_id    = 4'h0;
    cur_rdata = 32'h0;
  endtask

  // Returns at posedge+1 with reset released and the model cleared.
  task automatic apply_reset();
    obi_req = '0;
    wp      = 1'b0;
    clr     = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  task automatic reset_checks();
    chk("rst_rvalid", 32'(obi_rsp.rvalid), 32'h0);
    chk("rst_rdata", obi_rsp.r.rdata, 32'h0);
    chk("rst_rid", 32'(obi_rsp.r.rid), 32'h0);
    chk("rst_err", 32'(obi_rsp.r.err), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
  endtask

  // One clock cycle: drive inputs, update model, clock, compare outputs.
  task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [3:0] id, input logic p, input logic c);
    int          idx;
    logic        bad;
    logic [31:0] rd;
    exp_rsp_t    e;
    obi_req.req     = r;
    obi_req.a.we    = w;
    obi_req.a.addr  = a;
    obi_req.a.be    = b;
    obi_req.a.wdata = d;
    obi_req.a.aid   = id;
    wp              = p;
    clr             = c;
    #1;
    chk("gnt", 32'(obi_rsp.gnt), 32'(r));
    if (r) begin
      idx = int'((a >> 2) % 32'(IdxSpan));
      bad = (idx >= NW) || (w && p);
      rd  = 32'h0;
      if (!bad && w) begin
        for (int k = 0; k < 4; k++) begin
          if (b[k]) mdl_mem[idx][8*k +: 8] = d[8*k +: 8];
        end
      end else if (!bad) begin
        rd = mdl_mem[idx];
      end
      pend.push_back('{cyc + LAT, id, rd, bad});
    end
    if (c) mdl_cnt = 0;
    else if (cur_valid && cur_err && mdl_cnt < CntMax) mdl_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    cur_valid = 1'b0;
    cur_err   = 1'b0;
    cur_id    = 4'h0;
    cur_rdata = 32'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      cur_valid = 1'b1;
      cur_err   = e.err;
      cur_id    = e.id;
      cur_rdata = e.rdata;
    end
    if (obi_rsp.rvalid) begin
      dut_rsp_seen++;
      dut_last_rdata = obi_rsp.r.rdata;
      dut_last_id    = obi_rsp.r.rid;
      dut_last_err   = obi_rsp.r.err;
    end
    chk("rvalid", 32'(obi_rsp.rvalid), 32'(cur_valid));
    chk("rid", 32'(obi_rsp.r.rid), 32'(cur_id));
    chk("rdata", obi_rsp.r.rdata, cur_rdata);
    chk("err", 32'(obi_rsp.r.err), 32'(cur_err));
    chk("err_cnt", 32'(err_cnt), 32'(mdl_cnt));
  endtask

  task automatic idle(input int n, input logic c);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0, c);
  endtask

  initial begin
    int seen_before;
    cyc          = 0;
    dut_rsp_seen = 0;
    model_clear();

    vecs[0]  = '{1'b1, 32'h08, 4'hF, 32'hDEADBEEF, 4'd0,  1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h08, 4'hF, 32'h0,        4'd3,  1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h04, 4'h5, 32'h11223344, 4'd1,  1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h04, 4'h0, 32'h0,        4'd2,  1'b0, 32'h00220044, 1'b0};
    vecs[4]  = '{1'b0, 32'h30, 4'hF, 32'h0,        4'd5,  1'b0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h2C, 4'hF, 32'h0,        4'd6,  1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'h00, 4'hF, 32'hA5A5A5A5, 4'd7,  1'b1, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h00, 4'hF, 32'h0,        4'd8,  1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h4B, 4'hF, 32'h0,        4'd9,  1'b0, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b1, 32'h08, 4'h0, 32'hFFFFFFFF, 4'd10, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h08, 4'hF, 32'h0,        4'd11, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b0, 32'h3C, 4'hF, 32'h0,        4'd12, 1'b0, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'h08, 4'hF, 32'h0,        4'd13, 1'b1, 32'hDEADBEEF, 1'b0};

    apply_reset();
    reset_checks();

    // Directed table: one transaction, then wait out the latency
    for (int v = 0; v < 13; v++) begin
      seen_before = dut_rsp_seen;
      cycle(1'b1, vecs[v].we, vecs[v].addr, vecs[v].be, vecs[v].wdata, vecs[v].aid, vecs[v].wp, 1'b0);
      idle(LAT, 1'b0);
      chk($sformatf("vec%0d_seen", v), 32'(dut_rsp_seen - seen_before), 32'd1);
      chk($sformatf("vec%0d_rdata", v), dut_last_rdata, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_err", v), 32'(dut_last_err), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_rid", v), 32'(dut_last_id), 32'(vecs[v].aid));
    end

    // Error counter: clear, saturate, then clear racing an increment
    idle(1, 1'b1);
    chk("cnt_cleared", 32'(err_cnt), 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h30 + 32'(4 * (i % 4)), 4'hF, 32'h0, 4'(i), 1'b0, 1'b0);
    idle(LAT + 1, 1'b0);
    chk("cnt_saturated", 32'(err_cnt), 32'd3);
    idle(1, 1'b1);
    cycle(1'b1, 1'b0, 32'h30, 4'hF, 32'h0, 4'd6, 1'b0, 1'b0);
    idle(LAT - 1, 1'b0);
    idle(1, 1'b1);
    chk("cnt_clr_priority", 32'(err_cnt), 32'h0);

    // Back-to-back reads, then an asynchronous reset with responses in flight
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 32'(4 * i), 4'hF, 32'hC0DE0000 + 32'(i), 4'h0, 1'b0, 1'b0);
    idle(LAT, 1'b0);
    seen_before = dut_rsp_seen;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'(4 * i), 4'hF, 32'h0, 4'(i), 1'b0, 1'b0);
    chk("b2b_rsp_count", 32'(dut_rsp_seen - seen_before), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_drops_rvalid", 32'(obi_rsp.rvalid), 32'h0);
    apply_reset();
    reset_checks();
    seen_before = dut_rsp_seen;
    idle(LAT + 2, 1'b0);
    chk("no_rsp_after_rst", 32'(dut_rsp_seen - seen_before), 32'h0);
    for (int i = 0; i < NW; i++) cycle(1'b1, 1'b0, 32'(4 * i), 4'hF, 32'h0, 4'(i), 1'b0, 1'b0);
    idle(LAT, 1'b0);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom % 4) != 0, 1'($urandom % 2), 32'($urandom_range(0, 127)), 4'($urandom),
            32'($urandom), 4'($urandom), ($urandom % 5) == 0, ($urandom % 16) == 0);
    end
    idle(LAT + 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
